// File: rtl/serial_addsub_if.sv
// Operand/result bundle for serial_addsub: launch request and operands in,
// busy/done status and the held result out.
interface serial_addsub_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (output start, sub, a, b, input busy, done, sum, cout, ovf);
    modport slave  (input start, sub, a, b, output busy, done, sum, cout, ovf);
endinterface

// File: rtl/serial_addsub.sv
// Digit-serial adder/subtractor: one DIGIT-bit ripple slice reused over
// WIDTH/DIGIT cycles. Result, carry and overflow are held between completions.
module serial_addsub #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    serial_addsub_if.slave bus,
    output logic [1:0]     dbg_state
);
    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

    // Handshake: start is taken on any rising edge where busy is low (IDLE or
    // DONE); a, b and sub are sampled only on that edge, start is ignored
    // while busy is high, and done pulses for one cycle as the result lands.
    state_t state, state_next;

    logic [WIDTH-1:0]       opa, opb, acc, acc_next;
    logic                   carry;
    logic [CW-1:0]          cnt;
    logic                   accept, last;
    logic [DIGIT:0]         c;
    logic [DIGIT-1:0]       dsum;
    logic [WIDTH+DIGIT-1:0] cat;

    assign accept    = (state != RUN) && bus.start;
    assign last      = (cnt == CW'(N - 1));
    assign dbg_state = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.start) state_next = RUN;
            RUN:     if (last) state_next = DONE;
            DONE:    state_next = bus.start ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.busy = (state == RUN);
        bus.done = (state == DONE);
    end

    // One digit of ripple-carry addition on the operand LSBs.
    always_comb begin
        c    = '0;
        dsum = '0;
        c[0] = carry;
        for (int i = 0; i < DIGIT; i++) begin
            dsum[i]  = opa[i] ^ opb[i] ^ c[i];
            c[i + 1] = (opa[i] & opb[i]) | (c[i] & (opa[i] ^ opb[i]));
        end
        cat      = {dsum, acc};
        acc_next = cat[WIDTH+DIGIT-1:DIGIT];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opa     <= '0;
            opb     <= '0;
            acc     <= '0;
            carry   <= 1'b0;
            cnt     <= '0;
            bus.sum <= '0;
            bus.cout <= 1'b0;
            bus.ovf <= 1'b0;
        end else if (accept) begin
            // Subtraction is a + ~b + 1: the +1 enters as the initial carry.
            opa   <= bus.a;
            opb   <= bus.sub ? ~bus.b : bus.b;
            carry <= bus.sub;
            cnt   <= '0;
        end else if (state == RUN) begin
            opa   <= opa >> DIGIT;
            opb   <= opb >> DIGIT;
            acc   <= acc_next;
            carry <= c[DIGIT];
            cnt   <= cnt + 1'b1;
            if (last) begin
                bus.sum  <= acc_next;
                bus.cout <= c[DIGIT];
                bus.ovf  <= c[DIGIT-1] ^ c[DIGIT];
            end
        end
    end
endmodule
